conv1_window_mac: RTL
=====================

# conv1_window_mac

Conv1 compute stage directly downstream of the conv1 input-fetch block. Pops one 4-pixel column per cycle from its four row FIFOs, keeps a 3-column sliding window, and computes two vertically adjacent 3x3 convolution outputs per column using nine loadable signed weights. Results go out over a valid/ready stream, column by column, one band (4 input rows, 2 output rows) at a time, until the full image is covered.

## Interface
- IMG_W, 28, input image width/height in pixels
- BANDS, 13, bands per image (2 output rows each; 13 x 2 = 26 = IMG_W-2)
- DATA_W, 8, unsigned pixel width
- ACC_W, 21, signed result width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins an image when idle
- w_wr_en  in  1  weight write strobe
- w_addr  in  4  tap index 0..8, row-major (kr*3+kc)
- w_data  in  8  signed weight
- rd_data_0..rd_data_3  in  DATA_W  first-word-fall-through FIFO heads, input rows r..r+3
- empty_0..empty_3  in  1  FIFO empty flags
- rd_en  out  1  pop all four FIFOs this cycle
- out_valid  out  1  result pair valid
- out_ready  in  1  consumer accepts
- out_data_0  out  ACC_W  output row 2b, column out_col
- out_data_1  out  ACC_W  output row 2b+1, column out_col
- out_col  out  5  output column 0..IMG_W-3
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last result accepted

## Operation
- FSM: IDLE -> RUN on start (start ignored outside IDLE); RUN -> DRAIN after column IMG_W-1 of band BANDS-1 is popped; DRAIN -> IDLE when pipeline is empty, asserting done for that one cycle.
- advance = !out_valid || out_ready. rd_en = (state==RUN) && all four !empty && advance. Never pops when any FIFO is empty; partial pops are forbidden.
- On a pop: window shifts left by one column, the new column enters at position 2. col_cnt increments; at IMG_W-1 it wraps to 0 and band_cnt increments. Window contents are not cleared between bands; validity is governed by col_cnt.
- A pop with col_cnt >= 2 issues a compute for out_col = col_cnt-2; pops with col_cnt 0/1 only fill the window.
- out_data_0 = sum over kr,kc of w[kr*3+kc] * pix[kr][kc]; out_data_1 uses pix rows 1..3. Pixels are zero-extended to 9-bit signed; products 17-bit signed; sum of 9 sign-extended to ACC_W with no overflow possible.
- Weights writable only in IDLE; writes while busy or with w_addr > 8 are ignored. Weights persist across images.

## Timing
- 2-stage pipeline: products registered, then sum registered. Pop at cycle t -> out_valid at t+2 when not stalled.
- Whole pipeline stalls while out_valid && !out_ready; outputs hold stable during a stall.
- Throughput: 1 result pair per cycle when FIFOs are non-empty and out_ready=1; 26 pairs per band, 338 per image.
- Reset values: rd_en 0, out_valid 0, out_data_* 0, out_col 0, busy 0, done 0, all weights 0, counters 0, state IDLE.
- Reset mid-image aborts immediately; no done; the upstream block is reset by the same rst_n.
- busy rises the cycle after start; done and busy-fall occur in the same cycle.

## Configuration
- CONV1_RELU_EN defined: negative results clamp to 0 at the sum stage (same latency). Undefined: raw signed sums output.

## Structure
- Package conv1_pkg: IMG_W, BANDS, DATA_W, ACC_W, FSM state enum, product width constant.
- Sub-module conv1_mac9: 9-tap signed dot product, 2-stage, with stall enable; instantiated twice (rows 0..2, rows 1..3).

## Test plan
- Center tap w[4]=1, others 0; FIFO k row pixels = (row*28+col) mod 256 -> band 0 column 0 outputs 29 and 57; 338 pairs then done.
- All weights 1, all pixels 10 -> every output 90; pair count 338; out_col sequence 0..25 repeating.
- Hold out_ready=0 for 5 cycles mid-band -> outputs stable, rd_en low, no result lost or duplicated.
- Empty_2 asserted for 3 cycles mid-band -> rd_en low, no partial pop, results unchanged vs. no-gap run.
- All weights -1, pixels 10 -> -90 without CONV1_RELU_EN, 0 with it.
- Weight write and start during RUN -> both ignored; rst_n low mid-band -> all outputs at reset values, no done.

Source files
------------

// File: rtl/conv1_pkg.sv
`default_nettype none
// ============================================================================
// conv1_pkg : shared sizes, state encoding and widths for the conv1 MAC stage
// Rev 1.0
// ============================================================================
package conv1_pkg;

  localparam int IMG_W  = 28;
  localparam int BANDS  = 13;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 21;
  localparam int WGT_W  = 8;
  localparam int TAPS   = 9;
  // 9-bit zero-extended pixel times 8-bit signed weight
  localparam int PROD_W = DATA_W + 1 + WGT_W;
  localparam int COL_W  = 5;
  localparam int BAND_W = 4;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BANDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv1_mac9.sv
`default_nettype none
// ============================================================================
// conv1_mac9 : 9-tap signed dot product, products then sum registered, with stall
// Optional: CONV1_RELU_EN clamps negative sums to zero.  Rev 1.0
// ============================================================================
module conv1_mac9
  import conv1_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [TAPS-1:0][DATA_W-1:0]  pix,
  input  logic [TAPS-1:0][WGT_W-1:0]   wts,
  output logic signed [ACC_W-1:0]      sum
);

  logic signed [PROD_W-1:0] w_prod [TAPS];
  logic signed [PROD_W-1:0] r_prod [TAPS];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_res;
  logic signed [ACC_W-1:0]  r_sum;

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    assign w_prod[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'($signed(wts[i]));
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_sum = w_sum + ACC_W'(r_prod[i]);
    end
`ifdef CONV1_RELU_EN
    w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    w_res = w_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_prod[i] <= '0;
      end
      r_sum <= '0;
    end else if (en) begin
      for (int i = 0; i < TAPS; i++) begin
        r_prod[i] <= w_prod[i];
      end
      r_sum <= w_res;
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/conv1_window_mac.sv
`default_nettype none
// ============================================================================
// conv1_window_mac : 3-column sliding window over four row FIFOs, two 3x3 MACs
// Optional: CONV1_RELU_EN clamps negative results to zero.  Rev 1.0
// ============================================================================
module conv1_window_mac
  import conv1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              w_wr_en,
  input  logic [3:0]        w_addr,
  input  logic [7:0]        w_data,
  input  logic [DATA_W-1:0] rd_data_0,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  input  logic [DATA_W-1:0] rd_data_3,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  output logic              rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data_0,
  output logic [ACC_W-1:0]  out_data_1,
  output logic [4:0]        out_col,
  output logic              busy,
  output logic              done
);

  state_t                       r_state, w_state_nxt;
  logic                         r_busy, w_busy_nxt;
  logic                         r_done, w_done_nxt;
  logic [COL_W-1:0]             r_col_cnt, r_col_s1, r_col_s2;
  logic [BAND_W-1:0]            r_band_cnt;
  logic                         r_v1, r_v2;
  logic [1:0][3:0][DATA_W-1:0]  r_win;
  logic [3:0][DATA_W-1:0]       w_new;
  logic [TAPS-1:0][WGT_W-1:0]   r_wts;
  logic [TAPS-1:0][DATA_W-1:0]  w_pix_top, w_pix_bot;
  logic signed [ACC_W-1:0]      w_sum_top, w_sum_bot;
  logic                         w_advance, w_fifo_ok, w_pop, w_issue, w_last;

  assign w_new     = {rd_data_3, rd_data_2, rd_data_1, rd_data_0};
  assign w_advance = !r_v2 || out_ready;
  assign w_fifo_ok = !(empty_0 | empty_1 | empty_2 | empty_3);
  assign w_pop     = (r_state == ST_RUN) && w_fifo_ok && w_advance;
  assign w_issue   = w_pop && (r_col_cnt >= 5'd2);
  assign w_last    = (r_col_cnt == COL_LAST) && (r_band_cnt == BAND_LAST);

  // MACs see the post-shift window: two stored columns plus the FIFO heads
  for (genvar kr = 0; kr < 3; kr++) begin : g_row
    assign w_pix_top[kr*3+0] = r_win[0][kr];
    assign w_pix_top[kr*3+1] = r_win[1][kr];
    assign w_pix_top[kr*3+2] = w_new[kr];
    assign w_pix_bot[kr*3+0] = r_win[0][kr+1];
    assign w_pix_bot[kr*3+1] = r_win[1][kr+1];
    assign w_pix_bot[kr*3+2] = w_new[kr+1];
  end

  conv1_mac9 u_mac_top (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_advance),
    .pix   (w_pix_top),
    .wts   (r_wts),
    .sum   (w_sum_top)
  );

  conv1_mac9 u_mac_bot (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_advance),
    .pix   (w_pix_bot),
    .wts   (r_wts),
    .sum   (w_sum_bot)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_pop && w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_v1 && !r_v2) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Window contents survive band changes; col_cnt alone decides validity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win      <= '0;
      r_col_cnt  <= '0;
      r_band_cnt <= '0;
    end else if (w_pop) begin
      r_win[0] <= r_win[1];
      r_win[1] <= w_new;
      if (r_col_cnt == COL_LAST) begin
        r_col_cnt  <= '0;
        r_band_cnt <= (r_band_cnt == BAND_LAST) ? '0 : r_band_cnt + BAND_W'(1);
      end else begin
        r_col_cnt <= r_col_cnt + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_col_s1 <= '0;
      r_col_s2 <= '0;
    end else if (w_advance) begin
      r_v1 <= w_issue;
      r_v2 <= r_v1;
      if (w_issue) begin
        r_col_s1 <= r_col_cnt - 5'd2;
      end
      if (r_v1) begin
        r_col_s2 <= r_col_s1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wts <= '0;
    end else if (w_wr_en && (r_state == ST_IDLE) && (w_addr < 4'd9)) begin
      r_wts[w_addr] <= w_data;
    end
  end

  assign rd_en      = w_pop;
  assign out_valid  = r_v2;
  assign out_data_0 = w_sum_top;
  assign out_data_1 = w_sum_bot;
  assign out_col    = r_col_s2;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
